// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch issue, in-order response tagging and decode-side FIFO
// Stale responses after a redirect are counted in r_discard and dropped as they return.
module fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    output logic        pcAdvance,
    input  logic        flush,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        idValid,
    input  logic        idReady,
    output logic [31:0] idInstr,
    output logic [31:0] idPc,
    output logic [31:0] idPc4,
    output logic        idExcAdel
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    typedef logic [AW:0]   ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t W_DEPTH = cnt_t'(DEPTH);

    logic [31:0] r_d_instr [DEPTH];
    logic [31:0] r_d_pc    [DEPTH];
    logic [31:0] r_d_pc4   [DEPTH];
    logic        r_d_adel  [DEPTH];
    logic [31:0] r_t_pc    [DEPTH];
    logic [31:0] r_t_pc4   [DEPTH];

    ptr_t r_d_wr, r_d_rd, r_t_wr, r_t_rd;
    cnt_t r_inflight, r_discard;
    logic r_adel_pend;

    ptr_t          w_d_diff;
    cnt_t          w_count, w_used, w_outstanding, w_flush_discard;
    logic          w_credit, w_empty, w_aligned;
    logic          w_req, w_accept, w_drop, w_live, w_adel, w_push, w_pop;
    logic [AW-1:0] w_d_head, w_d_tail, w_t_head, w_t_tail;

    assign w_d_head  = r_d_rd[AW-1:0];
    assign w_d_tail  = r_d_wr[AW-1:0];
    assign w_t_head  = r_t_rd[AW-1:0];
    assign w_t_tail  = r_t_wr[AW-1:0];

    assign w_d_diff  = r_d_wr - r_d_rd;
    assign w_count   = {1'b0, w_d_diff};
    assign w_used    = w_count + r_inflight;
    assign w_credit  = (w_used < W_DEPTH);
    assign w_empty   = (r_d_wr == r_d_rd);
    assign w_aligned = (pc[1:0] == 2'b00);

    // Holding the issue while an AdEL entry waits keeps PC parked on the faulting address.
    assign w_req    = rst & ~flush & w_credit & w_aligned & ~r_adel_pend;
    assign w_accept = w_req & imemGnt;
    assign w_drop   = imemRvalid & (r_discard != '0);
    assign w_live   = imemRvalid & (r_discard == '0) & (r_inflight != '0);
    assign w_adel   = rst & ~flush & ~w_aligned & (r_inflight == '0) & w_credit & ~r_adel_pend;
    assign w_push   = w_live | w_adel;
    assign w_pop    = ~w_empty & idReady & ~flush;

    assign w_outstanding   = r_discard + r_inflight;
    assign w_flush_discard = w_outstanding - cnt_t'(imemRvalid & (w_outstanding != '0));

    always_ff @(posedge clk) begin
        if (w_push & ~flush) begin
            r_d_instr[w_d_tail] <= w_adel ? NOP_INSTR : imemRdata;
            r_d_pc[w_d_tail]    <= w_adel ? pc  : r_t_pc[w_t_head];
            r_d_pc4[w_d_tail]   <= w_adel ? pc4 : r_t_pc4[w_t_head];
            r_d_adel[w_d_tail]  <= w_adel;
        end
        if (w_accept) begin
            r_t_pc[w_t_tail]  <= pc;
            r_t_pc4[w_t_tail] <= pc4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_wr      <= '0;
            r_d_rd      <= '0;
            r_t_wr      <= '0;
            r_t_rd      <= '0;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_adel_pend <= 1'b0;
        end else if (flush) begin
            r_d_wr      <= '0;
            r_d_rd      <= '0;
            r_t_wr      <= '0;
            r_t_rd      <= '0;
            r_inflight  <= '0;
            r_discard   <= w_flush_discard;
            r_adel_pend <= 1'b0;
        end else begin
            if (w_push)
                r_d_wr <= r_d_wr + ptr_t'(1);
            if (w_pop)
                r_d_rd <= r_d_rd + ptr_t'(1);
            if (w_adel)
                r_adel_pend <= 1'b1;
            else if (w_pop && r_d_adel[w_d_head])
                r_adel_pend <= 1'b0;
            if (w_accept)
                r_t_wr <= r_t_wr + ptr_t'(1);
            if (w_live)
                r_t_rd <= r_t_rd + ptr_t'(1);
            if (w_drop)
                r_discard <= r_discard - cnt_t'(1);
            r_inflight <= r_inflight + cnt_t'(w_accept) - cnt_t'(w_live);
        end
    end

    assign imemReq   = w_req;
    assign imemAddr  = rst ? pc : 32'h0;
    assign pcAdvance = w_accept;
    assign idValid   = ~w_empty;
    assign idInstr   = w_empty ? 32'h0 : r_d_instr[w_d_head];
    assign idPc      = w_empty ? 32'h0 : r_d_pc[w_d_head];
    assign idPc4     = w_empty ? 32'h0 : r_d_pc4[w_d_head];
    assign idExcAdel = w_empty ? 1'b0  : r_d_adel[w_d_head];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized fetch_queue bench against a queue-based reference model
module tb_fetch_queue;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'h0, pc4 = 32'h4;
    logic        pcAdvance, flush = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0, imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic        idValid, idReady = 1'b0;
    logic [31:0] idInstr, idPc, idPc4;
    logic        idExcAdel;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc4(pc4), .pcAdvance(pcAdvance), .flush(flush),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt), .imemRvalid(imemRvalid),
        .imemRdata(imemRdata), .idValid(idValid), .idReady(idReady), .idInstr(idInstr),
        .idPc(idPc), .idPc4(idPc4), .idExcAdel(idExcAdel)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; logic adel; } ent_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] pc4; } tag_t;

    ent_t        m_q[$];
    tag_t        m_tags[$];
    int          m_discard;
    bit          m_adel_pend;
    logic [31:0] pops[$];
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          cyc, last_due;
    int          k_gnt, k_ready, k_flush, k_lat, k_mis;
    bit          f_force;
    logic [31:0] f_tgt, nxt_pc;
    int          checks, failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom();
        r[1:0] = ($urandom_range(99) < k_mis) ? 2'b10 : 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete(); m_tags.delete(); pops.delete();
        mem_addr.delete(); mem_due.delete();
        m_discard = 0; m_adel_pend = 0; last_due = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_imemReq"},   32'(imemReq),   32'h0);
        check({tag, "_imemAddr"},  imemAddr,       32'h0);
        check({tag, "_pcAdvance"}, 32'(pcAdvance), 32'h0);
        check({tag, "_idValid"},   32'(idValid),   32'h0);
        check({tag, "_idInstr"},   idInstr,        32'h0);
        check({tag, "_idPc"},      idPc,           32'h0);
        check({tag, "_idPc4"},     idPc4,          32'h0);
        check({tag, "_idExcAdel"}, 32'(idExcAdel), 32'h0);
    endtask

    // One clock: drive inputs at negedge, compare outputs against the model, advance the model.
    task automatic step();
        ent_t e;
        tag_t t;
        bit   cred, exp_req, acc, adel;
        int   d;
        @(negedge clk);
        cyc++;
        pc      = nxt_pc;
        pc4     = nxt_pc + 32'd4;
        flush   = f_force || ($urandom_range(99) < k_flush);
        imemGnt = ($urandom_range(99) < k_gnt);
        idReady = ($urandom_range(99) < k_ready);
        if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
            imemRvalid = 1'b1;
            imemRdata  = memfn(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imemRvalid = 1'b0;
            imemRdata  = $urandom();
        end
        #1;
        cred    = (m_q.size() + m_tags.size()) < DEPTH;
        exp_req = !flush && cred && (pc[1:0] == 2'b00) && !m_adel_pend;
        acc     = exp_req && imemGnt;
        check("imemReq",   32'(imemReq),   32'(exp_req));
        check("pcAdvance", 32'(pcAdvance), 32'(acc));
        check("imemAddr",  imemAddr,       pc);
        check("idValid",   32'(idValid),   32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("idInstr",   idInstr,        m_q[0].instr);
            check("idPc",      idPc,           m_q[0].pc);
            check("idPc4",     idPc4,          m_q[0].pc4);
            check("idExcAdel", 32'(idExcAdel), 32'(m_q[0].adel));
        end
        if (flush) begin
            d = m_discard + m_tags.size();
            if (imemRvalid && d > 0) d--;
            m_discard = d;
            m_tags.delete();
            m_q.delete();
            m_adel_pend = 0;
        end else begin
            adel = (pc[1:0] != 2'b00) && (m_tags.size() == 0) && cred && !m_adel_pend;
            if (m_q.size() > 0 && idReady) begin
                e = m_q.pop_front();
                pops.push_back(e.pc);
                if (e.adel) m_adel_pend = 0;
            end
            if (imemRvalid) begin
                if (m_discard > 0) m_discard--;
                else if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    e.instr = imemRdata; e.pc = t.pc; e.pc4 = t.pc4; e.adel = 1'b0;
                    m_q.push_back(e);
                end
            end
            if (acc) begin
                t.pc = pc; t.pc4 = pc4;
                m_tags.push_back(t);
            end
            if (adel) begin
                e.instr = NOP; e.pc = pc; e.pc4 = pc4; e.adel = 1'b1;
                m_q.push_back(e);
                m_adel_pend = 1;
            end
        end
        if (acc) begin
            d = cyc + 1 + $urandom_range(k_lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_addr.push_back(pc);
            mem_due.push_back(d);
        end
        if (flush) nxt_pc = f_force ? f_tgt : rand_target();
        else if (acc) nxt_pc = pc4;
        f_force = 0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0; f_force = 0; k_mis = 0;
        model_reset();

        // Reset with pc parked at 3000: every output stays 0.
        pc = 32'h0000_3000; pc4 = 32'h0000_3004; nxt_pc = 32'h0000_3000;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_imemReq",  32'(imemReq), 32'h1);
        check("rel_imemAddr", imemAddr,     32'h0000_3000);

        // Streaming: full grant, one-cycle latency, decode always ready.
        k_gnt = 100; k_ready = 100; k_flush = 0; k_lat = 0;
        repeat (8) step();
        check("stream_npops", 32'(pops.size() >= 3), 32'h1);
        if (pops.size() >= 3) begin
            check("stream_pop0", pops[0], 32'h0000_3000);
            check("stream_pop1", pops[1], 32'h0000_3004);
            check("stream_pop2", pops[2], 32'h0000_3008);
        end

        // Backpressure: decode stalls until the queue fills, then drains.
        k_ready = 0;
        repeat (5) step();
        check("bp_imemReq",   32'(imemReq),   32'h0);
        check("bp_pcAdvance", 32'(pcAdvance), 32'h0);
        k_ready = 100;
        repeat (6) step();

        // Redirect with a request in flight; the stale response must never reach decode.
        k_lat = 2;
        n = 0;
        while (m_tags.size() == 0 && n < 50) begin step(); n++; end
        check("flush_inflight_seen", 32'(m_tags.size() > 0), 32'h1);
        f_force = 1; f_tgt = 32'hBFC0_0380;
        step();
        pops.delete();
        repeat (10) step();
        check("flush_npops", 32'(pops.size() > 0), 32'h1);
        if (pops.size() > 0) check("flush_first_pc", pops[0], 32'hBFC0_0380);

        // Misaligned fetch produces one AdEL entry and holds PC.
        f_force = 1; f_tgt = 32'h1111_1112;
        step();
        k_ready = 0;
        repeat (4) step();
        check("adel_idValid",   32'(idValid),   32'h1);
        check("adel_idExcAdel", 32'(idExcAdel), 32'h1);
        check("adel_idInstr",   idInstr,        NOP);
        check("adel_idPc",      idPc,           32'h1111_1112);
        check("adel_imemReq",   32'(imemReq),   32'h0);
        check("adel_pcAdvance", 32'(pcAdvance), 32'h0);
        f_force = 1; f_tgt = 32'h0000_2000;
        step();

        // Randomized traffic with redirects, misaligned targets and variable latency.
        k_gnt = 70; k_ready = 60; k_flush = 8; k_lat = 3; k_mis = 15;
        repeat (3000) step();

        // Reset in the middle of traffic, then a late response with nothing issued.
        k_gnt = 100; k_ready = 0; k_flush = 0; k_lat = 3; k_mis = 0;
        f_force = 1; f_tgt = 32'h0000_4000;
        step();
        repeat (6) step();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_outputs_zero("midrst");
        model_reset();
        flush = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; idReady = 1'b0;
        pc = 32'h0000_5000; pc4 = 32'h0000_5004; nxt_pc = 32'h0000_5000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k_gnt = 0;
        mem_addr.push_back(32'h0000_0BAD);
        mem_due.push_back(cyc + 1);
        step();
        repeat (3) step();
        check("late_rvalid_idValid", 32'(idValid), 32'h0);
        k_gnt = 100; k_ready = 100;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
